// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD converter scheduler.
// The state encoding is fixed at 2 bits so the debug port stays compact.
package bcd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int BIN_W           = 12;
    localparam int BCD_W           = 16;
    localparam int TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from i_ptr with wrap-around.
// i_ptr is the first channel to consider, i.e. one past the previous grant.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [CH_W-1:0] o_gnt_ch,
    output logic            o_valid
);

    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) begin
            s = s - N_CH;
        end
        return CH_W'(s);
    endfunction

    // Walk from the farthest offset down so the closest requester wins last.
    always_comb begin
        o_gnt_ch = '0;
        o_valid  = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_req[wrap_idx(i_ptr, i)]) begin
                o_gnt_ch = wrap_idx(i_ptr, i);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one serial binary-to-BCD converter between N_CH requesters, sequencing
// the converter's level start/ready handshake and returning each result with a done pulse.
module bcd_conv_scheduler
    import bcd_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_CH-1:0]       i_req,
    input  logic [BIN_W*N_CH-1:0] i_bin_in,
    output logic [N_CH-1:0]       o_done,
    output logic [BCD_W-1:0]      o_bcd_out,
    output logic                  o_err,
    output logic                  o_busy,
    output logic                  o_conv_start,
    output logic [BIN_W-1:0]      o_conv_binary,
    input  logic [BCD_W-1:0]      i_conv_bcd,
    input  logic                  i_conv_ready,
    output state_t                o_state
);

    // Handshake with the converter: start is a level held until ready has been
    // seen; bcd is trusted only on the second consecutive ready cycle (SETTLE),
    // and a new start is never raised until ready has dropped again (RELEASE).

    localparam int CH_W  = $clog2(N_CH);
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             r_state;
    logic [CH_W-1:0]    r_gnt;
    logic [CH_W-1:0]    r_ptr;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_conv_start;
    logic [BIN_W-1:0]   r_conv_binary;
    logic [BCD_W-1:0]   r_bcd;
    logic [N_CH-1:0]    r_done;
    logic               r_err;

    logic [CH_W-1:0]    w_gnt;
    logic               w_valid;
    logic [CH_W-1:0]    w_next_ptr;
    logic [N_CH-1:0]    w_gnt_onehot;
    logic [BIN_W-1:0]   w_bin [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_bin
        assign w_bin[k] = i_bin_in[k*BIN_W +: BIN_W];
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_gnt_ch (w_gnt),
        .o_valid  (w_valid)
    );

    always_comb begin
        if (w_gnt == CH_W'(N_CH - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gnt + 1'b1;
        end
    end

    assign w_gnt_onehot = N_CH'(1) << r_gnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_ptr         <= '0;
            r_tmo_cnt     <= '0;
            r_conv_start  <= 1'b0;
            r_conv_binary <= '0;
            r_bcd         <= '0;
            r_done        <= '0;
            r_err         <= 1'b0;
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt         <= w_gnt;
                        r_ptr         <= w_next_ptr;
                        r_conv_binary <= w_bin[w_gnt];
                        r_tmo_cnt     <= '0;
                        r_conv_start  <= 1'b1;
                        r_state       <= ST_START;
                    end
                end
                ST_START: begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (i_conv_ready) begin
                        r_state <= ST_SETTLE;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        // Timed out: report on the same edge done would normally fire.
                        r_conv_start <= 1'b0;
                        r_done       <= w_gnt_onehot;
                        r_err        <= 1'b1;
                        r_bcd        <= '0;
                        r_state      <= ST_RELEASE;
                    end
                end
                ST_SETTLE: begin
                    r_conv_start <= 1'b0;
                    r_bcd        <= i_conv_bcd;
                    r_done       <= w_gnt_onehot;
                    r_state      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!i_conv_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_done        = r_done;
    assign o_bcd_out     = r_bcd;
    assign o_err         = r_err;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_conv_start  = r_conv_start;
    assign o_conv_binary = r_conv_binary;
    assign o_state       = r_state;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler with a 15-cycle behavioural converter.
// Requesters follow the drop-after-done rule; a negedge monitor pops and checks results.
module tb_bcd_conv_scheduler;
    import bcd_sched_pkg::*;

    localparam int N    = 4;
    localparam int TMO  = 32;
    localparam int L    = 15;
    localparam int SB_W = 1 + N + 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [12*N-1:0] bin_in = '0;
    logic [N-1:0]    done;
    logic [15:0]     bcd_out;
    logic            err;
    logic            busy;
    logic            conv_start;
    logic [11:0]     conv_binary;
    logic [15:0]     conv_bcd;
    logic            conv_ready;
    state_t          dbg_state;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [SB_W-1:0] exp_q[$];
    logic [11:0]     work_val [N][16];
    int              work_wr [N];
    int              work_rd [N];
    bit              stuck = 1'b0;
    bit              cadence_arm = 1'b0;

    bcd_conv_scheduler #(
        .N_CH    (N),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req         (req),
        .i_bin_in      (bin_in),
        .o_done        (done),
        .o_bcd_out     (bcd_out),
        .o_err         (err),
        .o_busy        (busy),
        .o_conv_start  (conv_start),
        .o_conv_binary (conv_binary),
        .i_conv_bcd    (conv_bcd),
        .i_conv_ready  (conv_ready),
        .o_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- converter model ----------------
    int   m_cnt = 0;
    logic m_rdy_q = 1'b0;

    function automatic logic [15:0] to_bcd(input logic [11:0] v);
        int x;
        x = int'(v);
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    assign conv_ready = !stuck && (m_cnt == L - 1);
    assign conv_bcd   = (conv_ready && m_rdy_q) ? to_bcd(conv_binary) : 16'hBAD0;

    always @(posedge clk) begin
        if (reset || !conv_start) begin
            m_cnt <= 0;
        end else if (m_cnt != L - 1) begin
            m_cnt <= m_cnt + 1;
        end
        m_rdy_q <= reset ? 1'b0 : conv_ready;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h, want no event (cycle %0d)", name, act, cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic queue_only(input int ch, input logic [11:0] val);
        work_val[ch][work_wr[ch]] = val;
        work_wr[ch]++;
    endtask

    task automatic issue(input int ch, input logic [11:0] val, input logic [15:0] exp_bcd, input logic exp_err);
        queue_only(ch, val);
        exp_q.push_back({exp_err, 4'(1 << ch), exp_bcd});
    endtask

    function automatic bit quiet();
        bit q;
        q = (exp_q.size() == 0) && !busy && (req == '0);
        for (int k = 0; k < N; k++) begin
            if (work_rd[k] != work_wr[k]) q = 1'b0;
        end
        return q;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        bit q;
        q = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (quiet()) begin
                q = 1'b1;
                break;
            end
        end
        check(name, 32'(q), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_conv_start"}, 32'(conv_start), 32'd0);
        check({tag, "_conv_binary"}, 32'(conv_binary), 32'd0);
        check({tag, "_bcd_out"}, 32'(bcd_out), 32'd0);
    endtask

    // Requesters: raise when work is queued, drop on the cycle of done.
    always @(negedge clk) begin
        if (reset) begin
            req = '0;
            for (int k = 0; k < N; k++) work_rd[k] = work_wr[k];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (done[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && (work_rd[k] != work_wr[k])) begin
                    bin_in[k*12 +: 12] = work_val[k][work_rd[k]];
                    work_rd[k]++;
                    req[k] = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic            prev_start = 1'b0;
    int              rise_cyc = 0;
    int              fr_cyc = 0;
    bit              fr_valid = 1'b0;
    bit              bin_unstable = 1'b0;
    logic [11:0]     held_bin = '0;
    bit              cad_valid = 1'b0;
    int              cad_prev = 0;
    logic [SB_W-1:0] item;

    always @(negedge clk) begin
        if (!cadence_arm) cad_valid = 1'b0;
        if (reset) begin
            prev_start   = 1'b0;
            fr_valid     = 1'b0;
            bin_unstable = 1'b0;
        end else begin
            if (conv_start && !prev_start) begin
                rise_cyc     = cyc;
                fr_valid     = 1'b0;
                held_bin     = conv_binary;
                bin_unstable = 1'b0;
                if (cadence_arm) begin
                    if (cad_valid) check("cadence", 32'(cyc - cad_prev), 32'(L + 4));
                    cad_valid = 1'b1;
                    cad_prev  = cyc;
                end
            end
            if (conv_start && conv_ready && !fr_valid) begin
                fr_valid = 1'b1;
                fr_cyc   = cyc;
            end
            if (busy && (conv_binary !== held_bin)) bin_unstable = 1'b1;
            if (prev_start && !conv_start) begin
                if (fr_valid) check("start_hold", 32'(cyc - fr_cyc), 32'd2);
                else check("timeout_drop", 32'(cyc - rise_cyc), 32'(TMO));
            end
            if ((done != '0) || err) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done", 32'({err, done, bcd_out}));
                end else begin
                    item = exp_q.pop_front();
                    check("sb_result", 32'({err, done, bcd_out}), 32'(item));
                    check("done_latency", 32'(cyc - rise_cyc), item[SB_W-1] ? 32'(TMO) : 32'(L + 1));
                    check("bin_stable", 32'(bin_unstable), 32'd0);
                end
            end
            prev_start = conv_start;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // All four at once: lowest index first after reset, then round-robin.
        issue(0, 12'd1,    16'h0001, 1'b0);
        issue(1, 12'd22,   16'h0022, 1'b0);
        issue(2, 12'd333,  16'h0333, 1'b0);
        issue(3, 12'd4095, 16'h4095, 1'b0);
        wait_quiet("all_four_drain", 200);

        // Single request on channel 2.
        issue(2, 12'd987, 16'h0987, 1'b0);
        wait_quiet("single_drain", 100);

        // Fairness: 0 and 1 keep re-requesting; grants must alternate at L+4 spacing.
        cadence_arm = 1'b1;
        issue(0, 12'd10, 16'h0010, 1'b0);
        issue(1, 12'd20, 16'h0020, 1'b0);
        issue(0, 12'd11, 16'h0011, 1'b0);
        issue(1, 12'd21, 16'h0021, 1'b0);
        issue(0, 12'd12, 16'h0012, 1'b0);
        issue(1, 12'd22, 16'h0022, 1'b0);
        issue(0, 12'd13, 16'h0013, 1'b0);
        issue(1, 12'd23, 16'h0023, 1'b0);
        wait_quiet("fairness_drain", 400);
        cadence_arm = 1'b0;

        // Converter never answers: timeout, then normal service resumes.
        stuck = 1'b1;
        issue(1, 12'd5, 16'h0000, 1'b1);
        wait_quiet("timeout_drain", 100);
        stuck = 1'b0;
        @(negedge clk);
        issue(0, 12'd42, 16'h0042, 1'b0);
        wait_quiet("after_timeout_drain", 100);

        // Reset while in SETTLE: transaction is abandoned with no done.
        queue_only(2, 12'd600);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (conv_ready) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("ready_before_reset", 32'(seen), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(3, 12'd1234, 16'h1234, 1'b0);
        wait_quiet("post_reset_drain", 100);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1);
    end

endmodule
